// File: rtl/vcii_sar_pkg.sv
// Shared definitions for the VCII SAR readout block: the FSM state type,
// the conversion width and the bit positions within the ui_in/uio buses.
package vcii_sar_pkg;

  localparam int unsigned N_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } sar_state_e;

  // ui_in bit positions
  localparam int unsigned UI_CMP   = 0;
  localparam int unsigned UI_START = 1;
  localparam int unsigned UI_CONT  = 2;

  // uio bit positions
  localparam int unsigned UIO_BUSY = 0;
  localparam int unsigned UIO_DONE = 1;
  localparam int unsigned UIO_SDO  = 2;
  localparam int unsigned UIO_SCLK = 3;

  localparam logic [7:0] UIO_OE_MASK = 8'b0000_0111;

endpackage

// File: rtl/vcii_sync.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clocks of latency)
module vcii_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vcii_sar_reader.sv
// Successive-approximation readout for a VCII z-node via an external R-2R DAC
// and comparator, with a serial shift-out of the last result.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design enable; low aborts any conversion
//   ui_in      : [0] cmp, [1] start, [2] cont
//   uo_out     : DAC trial code
//   uio_in     : [3] sclk serial readout clock
//   uio_out    : [0] busy, [1] done, [2] sdo
//   uio_oe     : constant output-enable mask
module vcii_sar_reader
  import vcii_sar_pkg::*;
#(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned N_BITS = vcii_sar_pkg::N_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned      IW       = $clog2(N_BITS);
  localparam logic [IW-1:0]    IDX_MSB  = IW'(N_BITS - 1);
  localparam logic [7:0]       CNT_LAST = 8'(SETTLE - 1);
  localparam logic [N_BITS-1:0] DAC_MID = {1'b1, {(N_BITS-1){1'b0}}};

  logic cmp_s, start_s, sclk_s;
  logic start_prev_q, sclk_prev_q;
  logic start_rise, sclk_rise;

  sar_state_e        state_q,  state_d;
  logic [7:0]        cnt_q,    cnt_d;
  logic [IW-1:0]     idx_q,    idx_d;
  logic [N_BITS-1:0] dac_q,    dac_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic [N_BITS-1:0] shift_q,  shift_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic [N_BITS-1:0] code;

  vcii_sync #(.WIDTH(1)) u_sync_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ui_in[UI_CMP]),
    .q_o   (cmp_s)
  );

  vcii_sync #(.WIDTH(1)) u_sync_start (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ui_in[UI_START]),
    .q_o   (start_s)
  );

  vcii_sync #(.WIDTH(1)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (uio_in[UIO_SCLK]),
    .q_o   (sclk_s)
  );

  assign start_rise = start_s & ~start_prev_q;
  assign sclk_rise  = sclk_s & ~sclk_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dac_d    = dac_q;
    result_d = result_q;
    shift_d  = shift_q;
    busy_d   = busy_q;
    done_d   = done_q;
    code     = dac_q;
    code[idx_q] = cmp_s;

    if (!ena) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = IDX_MSB;
      dac_d   = '0;
      busy_d  = 1'b0;
    end else begin
      if (sclk_rise) begin
        shift_d = {shift_q[N_BITS-2:0], 1'b0};
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
            idx_d   = IDX_MSB;
            dac_d   = DAC_MID;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end

        ST_SETTLE: begin
          // done is already low in a normal conversion; clearing it here
          // turns the continuous-mode done into a single-cycle pulse.
          done_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_SAMPLE: begin
          if (idx_q != '0) begin
            dac_d              = code;
            dac_d[idx_q-IW'(1)] = 1'b1;
            idx_d              = idx_q - IW'(1);
            state_d            = ST_SETTLE;
          end else begin
            result_d = code;
            shift_d  = code;  // overrides a coincident sclk shift
            done_d   = 1'b1;
            if (ui_in[UI_CONT]) begin
              state_d = ST_SETTLE;
              cnt_d   = '0;
              idx_d   = IDX_MSB;
              dac_d   = DAC_MID;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              dac_d   = code;
              busy_d  = 1'b0;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      dac_q        <= '0;
      result_q     <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
      sclk_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dac_q        <= dac_d;
      result_q     <= result_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= start_s;
      sclk_prev_q  <= sclk_s;
    end
  end

  assign uo_out = dac_q;
  assign uio_oe = UIO_OE_MASK;

  always_comb begin
    uio_out           = '0;
    uio_out[UIO_BUSY] = busy_q;
    uio_out[UIO_DONE] = done_q;
    uio_out[UIO_SDO]  = shift_q[N_BITS-1];
  end

  // Result register is kept for observability; unused input bits are sunk here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ui_in[7:3], uio_in[7:4], uio_in[2:0], result_q};

endmodule

// File: tb/tb_vcii_sar_reader.sv
module tb_vcii_sar_reader;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic       start = 1'b0;
  logic       cont  = 1'b0;
  logic       sclk  = 1'b0;
  logic [7:0] thr   = 8'h00;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  int tests = 0;
  int fails = 0;

  logic [7:0] trial [16];
  int         ntrial;
  int         busy_cycles;
  logic       conv_timeout;

  // Comparator model: z-node above the DAC level while the code does not exceed thr.
  assign ui_in  = {5'b0, cont, start, (uo_out <= thr)};
  assign uio_in = {4'b0, sclk, 3'b0};

  always #5 clk = ~clk;

  vcii_sar_reader #(.SETTLE(4), .N_BITS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Starts a conversion, waits for busy, counts busy cycles and records trial codes.
  task automatic run_conv(input logic [7:0] t, input int ign_at);
    int w;
    logic [7:0] last;
    thr = t;
    ntrial = 0;
    busy_cycles = 0;
    conv_timeout = 1'b0;
    start = 1'b1;
    w = 0;
    while (!uio_out[0] && w < 10) begin
      tick();
      w++;
    end
    start = 1'b0;
    if (w >= 10) conv_timeout = 1'b1;
    last = ~uo_out;
    while (uio_out[0] && busy_cycles < 100) begin
      if (uo_out !== last && ntrial < 16) begin
        trial[ntrial] = uo_out;
        ntrial++;
        last = uo_out;
      end
      busy_cycles++;
      if (busy_cycles == ign_at)     start = 1'b1;
      if (busy_cycles == ign_at + 3) start = 1'b0;
      tick();
    end
    if (busy_cycles >= 100) conv_timeout = 1'b1;
  endtask

  task automatic test_reset();
    tests++;
    if (uo_out !== 8'h00) begin fails++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
    tests++;
    if (uio_out !== 8'h00) begin fails++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
    tests++;
    if (uio_oe !== 8'h07) begin fails++; $display("FAIL reset_uio_oe got %h want 07", uio_oe); end
    rst_n = 1'b1;
    repeat (3) tick();
    tests++;
    if (uio_oe !== 8'h07) begin fails++; $display("FAIL post_reset_uio_oe got %h want 07", uio_oe); end
  endtask

  task automatic test_single();
    run_conv(8'hA5, -1);
    tests++;
    if (conv_timeout) begin fails++; $display("FAIL a5_timeout got timeout want completion"); end
    tests++;
    if (busy_cycles != 40) begin fails++; $display("FAIL a5_busy_cycles got %0d want 40", busy_cycles); end
    tests++;
    if (uo_out !== 8'hA5) begin fails++; $display("FAIL a5_result got %h want a5", uo_out); end
    tests++;
    if (uio_out[1] !== 1'b1) begin fails++; $display("FAIL a5_done got %b want 1", uio_out[1]); end
    repeat (5) tick();
    tests++;
    if (uio_out[1] !== 1'b1) begin fails++; $display("FAIL a5_done_sticky got %b want 1", uio_out[1]); end
  endtask

  task automatic test_serial();
    logic [7:0] exp_v;
    exp_v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (uio_out[2] !== exp_v[7-i]) begin
        fails++;
        $display("FAIL sdo_bit%0d got %b want %b", 7 - i, uio_out[2], exp_v[7-i]);
      end
      sclk = 1'b1;
      repeat (3) tick();
      sclk = 1'b0;
      repeat (3) tick();
    end
    tests++;
    if (uio_out[2] !== 1'b0) begin fails++; $display("FAIL sdo_after_8 got %b want 0", uio_out[2]); end
  endtask

  task automatic test_extremes();
    logic [7:0] exp_tr [8];
    exp_tr = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    run_conv(8'hFF, -1);
    tests++;
    if (conv_timeout || uo_out !== 8'hFF) begin
      fails++; $display("FAIL ff_result got %h timeout %b want ff", uo_out, conv_timeout);
    end
    tests++;
    if (ntrial != 8) begin fails++; $display("FAIL ff_trial_count got %0d want 8", ntrial); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (trial[i] !== exp_tr[i]) begin
        fails++; $display("FAIL ff_trial%0d got %h want %h", i, trial[i], exp_tr[i]);
      end
    end
    run_conv(8'h00, -1);
    tests++;
    if (conv_timeout || uo_out !== 8'h00 || busy_cycles != 40) begin
      fails++; $display("FAIL zero_result got %h busy %0d want 00 busy 40", uo_out, busy_cycles);
    end
  endtask

  task automatic test_start_while_busy();
    run_conv(8'hC3, 10);
    tests++;
    if (conv_timeout || busy_cycles != 40) begin
      fails++; $display("FAIL ignore_busy_cycles got %0d want 40", busy_cycles);
    end
    tests++;
    if (uo_out !== 8'hC3) begin fails++; $display("FAIL ignore_result got %h want c3", uo_out); end
    repeat (20) tick();
    tests++;
    if (uio_out[0] !== 1'b0) begin fails++; $display("FAIL ignore_no_restart got busy %b want 0", uio_out[0]); end
    tests++;
    if (uio_out[1] !== 1'b1 || uo_out !== 8'hC3) begin
      fails++; $display("FAIL ignore_hold got done %b code %h want done 1 code c3", uio_out[1], uo_out);
    end
  endtask

  task automatic test_ena_drop();
    int w;
    thr = 8'h5A;
    start = 1'b1;
    w = 0;
    while (!uio_out[0] && w < 10) begin tick(); w++; end
    start = 1'b0;
    tests++;
    if (w >= 10) begin fails++; $display("FAIL ena_start_timeout got no busy want busy"); end
    repeat (19) tick();
    ena = 1'b0;
    tick();
    tests++;
    if (uio_out[0] !== 1'b0 || uo_out !== 8'h00) begin
      fails++; $display("FAIL ena_abort got busy %b code %h want busy 0 code 00", uio_out[0], uo_out);
    end
    // done was cleared by the accepted start and must stay so; shift register keeps 0xC3.
    tests++;
    if (uio_out[1] !== 1'b0 || uio_out[2] !== 1'b1) begin
      fails++; $display("FAIL ena_retain got done %b sdo %b want done 0 sdo 1", uio_out[1], uio_out[2]);
    end
    repeat (10) tick();
    ena = 1'b1;
    repeat (3) tick();
    tests++;
    if (uio_out[0] !== 1'b0 || uio_out[2] !== 1'b1) begin
      fails++; $display("FAIL ena_idle got busy %b sdo %b want busy 0 sdo 1", uio_out[0], uio_out[2]);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    thr = 8'h77;
    start = 1'b1;
    w = 0;
    while (!uio_out[0] && w < 10) begin tick(); w++; end
    start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h07) begin
      fails++; $display("FAIL reset_mid got uo %h uio %h oe %h want 00 00 07", uo_out, uio_out, uio_oe);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_conv(8'h3C, -1);
    tests++;
    if (conv_timeout || busy_cycles != 40 || uo_out !== 8'h3C) begin
      fails++; $display("FAIL reset_restart got %h busy %0d want 3c busy 40", uo_out, busy_cycles);
    end
  endtask

  task automatic test_continuous();
    int w;
    int k;
    logic [7:0] rd;
    logic busy_low;
    busy_low = 1'b0;
    thr = 8'h40;
    cont = 1'b1;
    start = 1'b1;
    w = 0;
    while (!uio_out[0] && w < 10) begin tick(); w++; end
    start = 1'b0;
    w = 0;
    while (!uio_out[1] && w < 100) begin
      if (!uio_out[0]) busy_low = 1'b1;
      tick();
      w++;
    end
    tests++;
    if (w >= 100) begin fails++; $display("FAIL cont_first_done got timeout want done"); end
    tests++;
    if (uio_out[0] !== 1'b1 || uo_out !== 8'h80) begin
      fails++; $display("FAIL cont_restart got busy %b code %h want busy 1 code 80", uio_out[0], uo_out);
    end
    thr = 8'h3F;
    cont = 1'b0;
    tick();
    k = 1;
    tests++;
    if (uio_out[1] !== 1'b0) begin fails++; $display("FAIL cont_done_pulse got %b want 0", uio_out[1]); end
    rd = '0;
    for (int i = 0; i < 8; i++) begin
      rd[7-i] = uio_out[2];
      sclk = 1'b1;
      repeat (2) begin tick(); k++; if (!uio_out[0]) busy_low = 1'b1; end
      sclk = 1'b0;
      repeat (2) begin tick(); k++; if (!uio_out[0]) busy_low = 1'b1; end
    end
    while (!uio_out[1] && k < 80) begin
      if (!uio_out[0]) busy_low = 1'b1;
      tick();
      k++;
    end
    tests++;
    if (rd !== 8'h40) begin fails++; $display("FAIL cont_first_result got %h want 40", rd); end
    tests++;
    if (k != 40) begin fails++; $display("FAIL cont_done_spacing got %0d want 40", k); end
    tests++;
    if (busy_low) begin fails++; $display("FAIL cont_busy_gap got busy low want always high"); end
    tests++;
    if (uo_out !== 8'h3F || uio_out[1] !== 1'b1) begin
      fails++; $display("FAIL cont_second_result got %h done %b want 3f done 1", uo_out, uio_out[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    test_reset();
    test_single();
    test_serial();
    test_extremes();
    test_start_while_busy();
    test_ena_drop();
    test_reset_mid();
    test_continuous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
